hub75_fb_mem_arb: RTL
=====================

HUB75_FB_MEM_ARB -- requirements
Module: hub75_fb_mem_arb

Interface
REQ-001 Parameter AW, default 24, memory word address width.
REQ-002 Parameter WR_MAX_WAIT, default 64, cycles a pending write may wait before it gets priority over new reads.
REQ-003 Parameter WR_FIFO_DEPTH, default 4, write FIFO depth; power of two, at least 2.
REQ-004 clk_2x  in  1  clock; all logic is in this domain.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 fb_addr  in  AW  framebuffer read burst start address.
REQ-007 fb_do_read  in  1  framebuffer read request; level, held for the whole burst.
REQ-008 fb_rdata  out  32  read data from memory, passed through.
REQ-009 fb_next_word  out  1  strobe: fb_rdata is valid this cycle.
REQ-010 fb_is_idle  out  1  memory idle and owned by the read path.
REQ-011 wr_addr / wr_data / wr_valid / wr_ready  in AW / in 32 / in 1 / out 1  single-word write port with valid/ready handshake.
REQ-012 mem_addr / mem_wdata  out AW / out 32  QPI controller address and write data.
REQ-013 mem_do_read / mem_do_write  out 1 / out 1  QPI controller level requests.
REQ-014 mem_rdata / mem_next_word / mem_is_idle  in 32 / in 1 / in 1  QPI controller read data, word strobe and idle flag.

Function
REQ-015 The FSM SHALL have the states IDLE, RD, RD_DRAIN, WR and WR_DRAIN.
REQ-016 IDLE: if fb_do_read is high and the starve flag is low, the FSM SHALL go to RD; otherwise, if the write buffer is non-empty and mem_is_idle is high, it SHALL go to WR.
REQ-017 RD: mem_do_read SHALL equal fb_do_read, mem_addr SHALL equal fb_addr, and fb_next_word SHALL equal mem_next_word combinationally; when fb_do_read falls, the FSM SHALL go to RD_DRAIN.
REQ-018 RD_DRAIN: mem_do_read SHALL be low; mem_next_word SHALL still be forwarded to fb_next_word, covering the trailing word after the request drops; on mem_is_idle the FSM SHALL go to IDLE.
REQ-019 fb_rdata SHALL equal mem_rdata at all times; fb_next_word SHALL be 0 outside RD and RD_DRAIN.
REQ-020 WR: mem_do_write SHALL be high, and mem_addr and mem_wdata SHALL be the write-buffer head; mem_next_word SHALL pop the head, drop mem_do_write on the next cycle, and move the FSM to WR_DRAIN.
REQ-021 WR_DRAIN: on mem_is_idle the FSM SHALL go to IDLE; each write is a single-word transaction.
REQ-022 A read burst in progress SHALL never be pre-empted; a write SHALL never start while mem_is_idle is low.
REQ-023 The wait counter SHALL increment, saturating at WR_MAX_WAIT, while the buffer is non-empty and the state is not WR; it SHALL clear when entering WR; starve = (counter == WR_MAX_WAIT).
REQ-024 fb_is_idle SHALL be mem_is_idle while the state is IDLE, RD or RD_DRAIN, and 0 otherwise.
REQ-025 wr_ready SHALL be high iff the buffer is not full; on a simultaneous push and pop the occupancy SHALL stay unchanged.
REQ-026 Pointers SHALL wrap modulo WR_FIFO_DEPTH; full/empty SHALL use a one-bit-wider occupancy count.
REQ-027 mem_do_read and mem_do_write SHALL never be high in the same cycle.

Reset
REQ-028 Reset SHALL force: state IDLE, buffer empty, wait counter 0, mem_do_read 0, mem_do_write 0, fb_next_word 0, wr_ready 1 (asserted from the first cycle after reset).
REQ-029 Reset during RD or WR SHALL drop mem_do_read and mem_do_write in the same cycle; buffered writes are discarded.

Configuration
REQ-030 With HUB75_ARB_WR_FIFO_EN defined, the write buffer SHALL be a WR_FIFO_DEPTH-entry FIFO.
REQ-031 Without HUB75_ARB_WR_FIFO_EN, the buffer SHALL be a single holding register, so wr_ready is low from accept until that word's mem_next_word; all other behaviour is unchanged.

Structure
REQ-032 The FSM state encodings SHALL be defined in the shared package hub75_pkg.
REQ-033 The write buffer SHALL be one sub-module, hub75_arb_wr_fifo (synchronous FIFO, parameterised depth and width).

Verification
REQ-034 Read burst: fb_do_read high 31 cycles, then 1 trailing strobe in RD_DRAIN, addr 0x000400 -> mem_addr 0x000400, 32 fb_next_word pulses, then IDLE.
REQ-035 Write: wr_addr 0x000010, wr_data 0xDEADBEEF, accepted while idle -> one mem_do_write with those values; wr_ready stays 1 (FIFO build).
REQ-036 Read then write: write posted during a read burst -> the write starts only after RD_DRAIN and mem_is_idle; the read burst is uninterrupted.
REQ-037 Starvation: fb_do_read held high back-to-back with a write pending and WR_MAX_WAIT=8 -> the write is issued at the first IDLE after 8 waiting cycles.
REQ-038 FIFO full: 5 writes with mem_is_idle held low -> wr_ready falls after the 4th; then 4 writes issue in order.
REQ-039 Reset mid-WR: rst asserted while mem_do_write is high -> mem_do_write is 0 the next cycle and wr_ready is 1.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 framebuffer memory arbiter.
package hub75_pkg;

  localparam int ARB_DW = 32;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_RD       = 3'd1,
    ARB_RD_DRAIN = 3'd2,
    ARB_WR       = 3'd3,
    ARB_WR_DRAIN = 3'd4
  } arb_state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hub75_arb_wr_fifo.sv
// Synchronous write-buffer FIFO; DEPTH must be 1 or a power of two.
module hub75_arb_wr_fifo
  import hub75_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 56
) (
  input  logic         clk_2x,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW    = ptr_w(DEPTH);
  localparam int CW    = PW + 1;
  localparam int SLOTS = 2 ** PW;

  logic [W-1:0]  mem_q [SLOTS];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = push_ok ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop_ok  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_2x) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_2x) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/hub75_fb_mem_arb.sv
// Arbitrates the QPI memory between framebuffer read bursts and buffered single-word writes.
// Define HUB75_ARB_WR_FIFO_EN for a WR_FIFO_DEPTH-entry write FIFO; otherwise one holding register.
module hub75_fb_mem_arb
  import hub75_pkg::*;
#(
  parameter int AW            = 24,
  parameter int WR_MAX_WAIT   = 64,
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic              clk_2x,
  input  logic              rst,
  input  logic [AW-1:0]     fb_addr,
  input  logic              fb_do_read,
  output logic [ARB_DW-1:0] fb_rdata,
  output logic              fb_next_word,
  output logic              fb_is_idle,
  input  logic [AW-1:0]     wr_addr,
  input  logic [ARB_DW-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [AW-1:0]     mem_addr,
  output logic [ARB_DW-1:0] mem_wdata,
  output logic              mem_do_read,
  output logic              mem_do_write,
  input  logic [ARB_DW-1:0] mem_rdata,
  input  logic              mem_next_word,
  input  logic              mem_is_idle
);

`ifdef HUB75_ARB_WR_FIFO_EN
  localparam int BUF_DEPTH = WR_FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif
  localparam int WCW = $clog2(WR_MAX_WAIT + 1);

  arb_state_e            state_q, state_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic [AW+ARB_DW-1:0]  head;
  logic                  buf_full, buf_empty, buf_pop, starve;

  assign buf_pop  = (state_q == ARB_WR) & mem_next_word;
  assign wr_ready = ~buf_full;
  assign starve   = (wait_q == WCW'(WR_MAX_WAIT));
  assign fb_rdata = mem_rdata;

  hub75_arb_wr_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (AW + ARB_DW)
  ) u_wr_fifo (
    .clk_2x  (clk_2x),
    .rst     (rst),
    .push_i  (wr_valid),
    .din_i   ({wr_addr, wr_data}),
    .pop_i   (buf_pop),
    .dout_o  (head),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  always_comb begin
    state_d      = state_q;
    mem_do_read  = 1'b0;
    mem_do_write = 1'b0;
    fb_next_word = 1'b0;
    fb_is_idle   = 1'b0;
    mem_addr     = fb_addr;
    mem_wdata    = head[ARB_DW-1:0];
    case (state_q)
      ARB_IDLE: begin
        fb_is_idle = mem_is_idle;
        if (fb_do_read && !starve)           state_d = ARB_RD;
        else if (!buf_empty && mem_is_idle)  state_d = ARB_WR;
      end
      ARB_RD: begin
        fb_is_idle   = mem_is_idle;
        mem_do_read  = fb_do_read;
        fb_next_word = mem_next_word;
        if (!fb_do_read) state_d = ARB_RD_DRAIN;
      end
      ARB_RD_DRAIN: begin
        // Controller may still deliver the last word after the request drops.
        fb_is_idle   = mem_is_idle;
        fb_next_word = mem_next_word;
        if (mem_is_idle) state_d = ARB_IDLE;
      end
      ARB_WR: begin
        mem_do_write = 1'b1;
        mem_addr     = head[AW+ARB_DW-1:ARB_DW];
        if (mem_next_word) state_d = ARB_WR_DRAIN;
      end
      ARB_WR_DRAIN: begin
        if (mem_is_idle) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    // Requests must drop in the reset cycle itself, not one cycle later.
    if (rst) begin
      mem_do_read  = 1'b0;
      mem_do_write = 1'b0;
      fb_next_word = 1'b0;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d == ARB_WR && state_q != ARB_WR)
      wait_d = '0;
    else if (!buf_empty && state_q != ARB_WR && !starve)
      wait_d = wait_q + WCW'(1);
  end

  always_ff @(posedge clk_2x) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule
